fsmd_host_link: RTL
===================

# fsmd_host_link

Host-side transaction engine for the FSM+D datapath. It accepts five 4-bit operands as a nibble stream over a valid/ready handshake and presents them as parallel operands a..e. It then pulses a restart to the FSM+D, waits a fixed settle time, captures the result registers R1..R3, and returns them as a three-nibble stream over a second valid/ready handshake.

## Interface
- SETTLE_CYCLES, 8, number of cycles spent in WAIT before results are captured; legal range 1..255.
- clock  in  1  single clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low; sampled on the rising edge of clock.
- in_data  in  4  operand nibble; order is a, b, c, d, e.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block accepts a nibble; high only in LOAD.
- a, b, c, d, e  out  4 each  operand registers driven to the FSM+D.
- fsmd_rst  out  1  active-high, registered, one-cycle restart pulse to the FSM+D.
- R1, R2, R3  in  4 each  FSM+D result registers.
- out_data  out  4  result nibble; order is R1, R2, R3.
- out_valid  out  1  out_data is valid; high only in SEND.
- out_ready  in  1  consumer accepts out_data.
- busy  out  1  high in every state except LOAD.
- st  out  3  current state code, for debug.

## Operation
- States and codes: LOAD=0, KICK=1, WAIT=2, CAPTURE=3, SEND=4. Codes 5–7 are unreachable; if entered, the next state is LOAD.
- LOAD:
  - in_ready=1.
  - On each in_valid&in_ready edge, in_data is written to operand[idx] and idx increments.
  - idx is 3 bits, counts 0..4, and returns to 0 after e is written.
  - The handshake that writes e moves the state to KICK.
- KICK: fsmd_rst=1 for exactly this cycle. WAIT is next.
- WAIT: a down-counter is loaded with SETTLE_CYCLES-1 on entry and decrements each cycle. When it reaches 0, CAPTURE is next, so WAIT lasts exactly SETTLE_CYCLES cycles.
- CAPTURE: R1..R3 are registered into cap0..cap2 at the end of this cycle. SEND is next.
- SEND:
  - out_valid=1 and out_data=cap[oidx].
  - oidx advances on each out_valid&out_ready edge.
  - After the cap2 handshake the state returns to LOAD and oidx returns to 0.
- Operand stability: a..e change only during LOAD handshakes. They hold from KICK through SEND and keep their values into the next LOAD until overwritten.
- in_valid outside LOAD is ignored; no data is consumed.
- No arithmetic is performed on data. Counters never exceed their declared ranges.

## Timing
- Reset (first edge with reset=0) sets:
  - state=LOAD, idx=0, oidx=0;
  - a..e=0, cap0..2=0;
  - fsmd_rst=0, out_valid=0, out_data=0, busy=0, st=0;
  - in_ready=1 from the cycle after that edge.
  
  reset=0 held for several cycles keeps all of these values.
- The minimum load takes 5 consecutive cycles with in_valid=1. Gaps in in_valid only stretch LOAD.
- Let edge k be the one that accepts e:
  - cycle k+1: KICK, fsmd_rst=1;
  - cycles k+2..k+1+SETTLE_CYCLES: WAIT;
  - cycle k+2+SETTLE_CYCLES: CAPTURE;
  - cycle k+3+SETTLE_CYCLES: first out_valid=1.
- With out_ready held high, R1, R2, R3 appear on three consecutive cycles, and in_ready=1 on the following cycle.
- Back-pressure: while out_valid=1 and out_ready=0, out_data and oidx hold. The stall may last indefinitely.
- Reset mid-operation (any state) discards the following, with no partial output and no further fsmd_rst pulse:
  - the in-progress load;
  - the settle count;
  - the captured results.
- There is no simultaneous in/out handshake: LOAD and SEND are mutually exclusive.

## Test plan
- Basic transaction, SETTLE_CYCLES=8:
  - stimulus: stream 1,2,3,4,5 back-to-back; drive R1=4'hA, R2=4'hB, R3=4'hC; out_ready=1;
  - required: a..e=1..5; fsmd_rst high exactly at k+1; out_data A,B,C at cycles k+11..k+13; in_ready=1 at k+14.
- Input gaps: stream 9,0,F,7,6 with in_valid low for 2 cycles between each nibble → a..e=9,0,F,7,6, and KICK follows only the e handshake.
- Output back-pressure: out_ready=0 for 5 cycles after out_valid rises, then toggles 1,0,1,0,1 → out_data holds A while stalled; exactly three beats A,B,C are delivered.
- Ignored input: in_valid=1 with in_data=F throughout KICK..SEND → operands unchanged, in_ready=0, busy=1.
- Reset mid-WAIT: reset=0 for one edge during WAIT → next cycle st=0, a..e=0, out_valid never rises, fsmd_rst stays 0; a fresh load then completes normally.
- SETTLE_CYCLES=1 boundary → exactly one WAIT cycle; first out_valid at k+4.

Source files
------------

// File: rtl/fsmd_host_link_if.sv
// Nibble-stream handshakes between a host and fsmd_host_link: operand stream in, result stream out.
interface fsmd_host_link_if;
  logic [3:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] out_data;
  logic       out_valid;
  logic       out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid
  );
endinterface

// File: rtl/fsmd_host_link.sv
// Host engine: loads operands a..e, pulses fsmd_rst, waits SETTLE_CYCLES, streams R1..R3 back.
// First result SETTLE_CYCLES+3 cycles after the e handshake; result stream holds indefinitely on out_ready=0.
module fsmd_host_link #(
  parameter int SETTLE_CYCLES = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  fsmd_host_link_if.slave        link,
  output logic [3:0]             a,
  output logic [3:0]             b,
  output logic [3:0]             c,
  output logic [3:0]             d,
  output logic [3:0]             e,
  output logic                   fsmd_rst,
  input  logic [3:0]             R1,
  input  logic [3:0]             R2,
  input  logic [3:0]             R3,
  output logic                   busy,
  output logic [2:0]             st
);

  typedef enum logic [2:0] {
    S_LOAD    = 3'd0,
    S_KICK    = 3'd1,
    S_WAIT    = 3'd2,
    S_CAPTURE = 3'd3,
    S_SEND    = 3'd4
  } state_t;

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);

  state_t     state;
  logic [2:0] idx;
  logic [1:0] oidx;
  logic [7:0] cnt;
  logic [3:0] cap0, cap1, cap2;
  logic       in_hs;
  logic       out_hs;

  assign in_hs  = link.in_valid & link.in_ready;
  assign out_hs = link.out_valid & link.out_ready;
  assign st     = state;

  // oidx only ever selects a captured register, so out_data is a pure register mux.
  assign link.out_data = (oidx == 2'd0) ? cap0 :
                         (oidx == 2'd1) ? cap1 : cap2;

  always_ff @(posedge clock) begin
    if (!reset) begin
      state         <= S_LOAD;
      idx           <= '0;
      oidx          <= '0;
      cnt           <= '0;
      a             <= '0;
      b             <= '0;
      c             <= '0;
      d             <= '0;
      e             <= '0;
      cap0          <= '0;
      cap1          <= '0;
      cap2          <= '0;
      fsmd_rst      <= 1'b0;
      busy          <= 1'b0;
      link.in_ready <= 1'b1;
      link.out_valid <= 1'b0;
    end else begin
      fsmd_rst <= 1'b0;
      case (state)
        S_LOAD: begin
          if (in_hs) begin
            case (idx)
              3'd0:    a <= link.in_data;
              3'd1:    b <= link.in_data;
              3'd2:    c <= link.in_data;
              3'd3:    d <= link.in_data;
              default: e <= link.in_data;
            endcase
            if (idx == 3'd4) begin
              idx           <= '0;
              state         <= S_KICK;
              fsmd_rst      <= 1'b1;
              busy          <= 1'b1;
              link.in_ready <= 1'b0;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end

        S_KICK: begin
          cnt   <= SETTLE_LAST;
          state <= S_WAIT;
        end

        // Loaded with SETTLE_CYCLES-1 so WAIT spans exactly SETTLE_CYCLES cycles.
        S_WAIT: begin
          if (cnt == 8'd0) begin
            state <= S_CAPTURE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end

        S_CAPTURE: begin
          cap0           <= R1;
          cap1           <= R2;
          cap2           <= R3;
          oidx           <= '0;
          link.out_valid <= 1'b1;
          state          <= S_SEND;
        end

        S_SEND: begin
          if (out_hs) begin
            if (oidx == 2'd2) begin
              oidx           <= '0;
              link.out_valid <= 1'b0;
              link.in_ready  <= 1'b1;
              busy           <= 1'b0;
              state          <= S_LOAD;
            end else begin
              oidx <= oidx + 2'd1;
            end
          end
        end

        default: begin
          state          <= S_LOAD;
          idx            <= '0;
          oidx           <= '0;
          busy           <= 1'b0;
          link.in_ready  <= 1'b1;
          link.out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
